// File: rtl/ex_pkg.sv
// ============================================================================
// Module : ex_pkg
// Brief  : Shared opcodes, FSM state and control-bundle types for the EX stage.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package ex_pkg;

    localparam logic [2:0] c_op_add = 3'd0;
    localparam logic [2:0] c_op_sub = 3'd1;
    localparam logic [2:0] c_op_and = 3'd2;
    localparam logic [2:0] c_op_or  = 3'd3;
    localparam logic [2:0] c_op_xor = 3'd4;
    localparam logic [2:0] c_op_sll = 3'd5;
    localparam logic [2:0] c_op_srl = 3'd6;
    localparam logic [2:0] c_op_mul = 3'd7;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    typedef struct packed {
        logic reg_write;
        logic branch;
        logic mem_read;
        logic mem_write;
        logic mem_to_reg;
        logic mov;
    } ctrl_t;

    localparam ctrl_t c_ctrl_bubble = '0;

endpackage

`default_nettype wire

// File: rtl/mul_iter.sv
// ============================================================================
// Module : mul_iter
// Brief  : Iterative shift-add multiplier, one partial product per step.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mul_iter #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    input  logic                  i_run,
    input  logic                  i_abort,
    input  logic                  i_hold,
    input  logic [DATA_WIDTH-1:0] i_a,
    input  logic [DATA_WIDTH-1:0] i_b,
    output logic                  o_done,
    output logic [DATA_WIDTH-1:0] o_product
);

    localparam int c_cnt_w = $clog2(DATA_WIDTH);

    logic [DATA_WIDTH-1:0] r_a;
    logic [DATA_WIDTH-1:0] r_b;
    logic [DATA_WIDTH-1:0] r_acc;
    logic [c_cnt_w-1:0]    r_cnt;

    logic                  w_step;
    logic                  w_last;
    logic [DATA_WIDTH-1:0] w_partial;

    assign w_step    = i_run & ~i_abort & ~i_hold;
    assign w_last    = (r_cnt == c_cnt_w'(DATA_WIDTH - 1));
    assign w_partial = r_b[r_cnt] ? (r_a << r_cnt) : '0;
    // On the final step this sum is the full (truncated) product.
    assign o_product = r_acc + w_partial;
    assign o_done    = w_step & w_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a   <= '0;
            r_b   <= '0;
            r_acc <= '0;
            r_cnt <= '0;
        end else if (i_abort) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if (i_start) begin
            r_a   <= i_a;
            r_b   <= i_b;
            r_acc <= '0;
            r_cnt <= '0;
        end else if (w_step) begin
            if (w_last) begin
                r_acc <= '0;
                r_cnt <= '0;
            end else begin
                r_acc <= o_product;
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/ex_stage_mc.sv
// ============================================================================
// Module : ex_stage_mc
// Brief  : Execute stage with forwarding, single-cycle ALU, multi-cycle MUL.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ex_stage_mc
    import ex_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int ADDR_WIDTH  = 8,
    parameter int IMM8_WIDTH  = 8,
    parameter int REG_WIDTH   = 4,
    parameter int ALUOP_WIDTH = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [ADDR_WIDTH-1:0]  PCE_i,
    input  logic [DATA_WIDTH-1:0]  r1_data_r_i,
    input  logic [DATA_WIDTH-1:0]  r2_data_r_i,
    input  logic [IMM8_WIDTH-1:0]  imm8E_i,
    input  logic [REG_WIDTH-1:0]   rsE_i,
    input  logic [REG_WIDTH-1:0]   rtE_i,
    input  logic [REG_WIDTH-1:0]   rdE_i,
    input  logic [ALUOP_WIDTH-1:0] ALUopE_i,
    input  logic                   ALUSrcE_i,
    input  logic                   RegWriteE_i,
    input  logic                   BranchE_i,
    input  logic                   MemReadE_i,
    input  logic                   MemWriteE_i,
    input  logic                   MemToRegE_i,
    input  logic                   MovE_i,
    input  logic                   RegDstE_i,
    input  logic [DATA_WIDTH-1:0]  WBResultM_i,
    input  logic [DATA_WIDTH-1:0]  ResultW_i,
    input  logic [1:0]             alu_src1_i,
    input  logic [1:0]             alu_src2_i,
    input  logic                   flush_EX_MEM_i,
    input  logic                   stall_EX_MEM_i,
    output logic                   busy_o,
    output logic [ADDR_WIDTH-1:0]  PCM_o,
    output logic [DATA_WIDTH-1:0]  WriteDataM_o,
    output logic [IMM8_WIDTH-1:0]  imm8M_o,
    output logic [REG_WIDTH-1:0]   rsM_o,
    output logic [REG_WIDTH-1:0]   WriteRegM_o,
    output logic [DATA_WIDTH-1:0]  alu_outM_o,
    output logic                   ZeroM_o,
    output logic                   RegWriteM_o,
    output logic                   BranchM_o,
    output logic                   MemReadM_o,
    output logic                   MemWriteM_o,
    output logic                   MemToRegM_o,
    output logic                   MovM_o
);

    localparam int c_shw = $clog2(DATA_WIDTH);

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  w_accept;
    logic                  w_bubble;
    logic                  w_load_alu;
    logic                  w_load_mul;
    logic                  w_mul_done;
    logic [DATA_WIDTH-1:0] w_mul_product;

    logic [DATA_WIDTH-1:0] w_op1;
    logic [DATA_WIDTH-1:0] w_fwd2;
    logic [DATA_WIDTH-1:0] w_op2;
    logic [DATA_WIDTH-1:0] w_alu;
    logic [REG_WIDTH-1:0]  w_wreg_e;
    ctrl_t                 w_ctrl_e;
    logic                  w_unused;

    // Fields captured when a MUL is accepted; the live ID/EX inputs are ignored afterwards.
    logic [ADDR_WIDTH-1:0] r_l_pc;
    logic [DATA_WIDTH-1:0] r_l_wdata;
    logic [IMM8_WIDTH-1:0] r_l_imm;
    logic [REG_WIDTH-1:0]  r_l_rs;
    logic [REG_WIDTH-1:0]  r_l_wreg;
    ctrl_t                 r_l_ctrl;

    logic [ADDR_WIDTH-1:0] w_src_pc;
    logic [DATA_WIDTH-1:0] w_src_wdata;
    logic [IMM8_WIDTH-1:0] w_src_imm;
    logic [REG_WIDTH-1:0]  w_src_rs;
    logic [REG_WIDTH-1:0]  w_src_wreg;
    logic [DATA_WIDTH-1:0] w_src_res;
    ctrl_t                 w_src_ctrl;

    logic [ADDR_WIDTH-1:0] r_pc;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [IMM8_WIDTH-1:0] r_imm;
    logic [REG_WIDTH-1:0]  r_rs;
    logic [REG_WIDTH-1:0]  r_wreg;
    logic [DATA_WIDTH-1:0] r_res;
    logic                  r_zero;
    ctrl_t                 r_ctrl;

    assign w_unused = ^rtE_i;
    assign w_ctrl_e = {RegWriteE_i, BranchE_i, MemReadE_i, MemWriteE_i, MemToRegE_i, MovE_i};
    assign w_wreg_e = RegDstE_i ? rsE_i : rdE_i;

    always_comb begin
        w_op1  = r1_data_r_i;
        w_fwd2 = r2_data_r_i;
        case (alu_src1_i)
            2'd1:    w_op1 = WBResultM_i;
            2'd2:    w_op1 = ResultW_i;
            default: w_op1 = r1_data_r_i;
        endcase
        case (alu_src2_i)
            2'd1:    w_fwd2 = WBResultM_i;
            2'd2:    w_fwd2 = ResultW_i;
            default: w_fwd2 = r2_data_r_i;
        endcase
        w_op2 = ALUSrcE_i ? {{(DATA_WIDTH-IMM8_WIDTH){imm8E_i[IMM8_WIDTH-1]}}, imm8E_i} : w_fwd2;
    end

    always_comb begin
        w_alu = '0;
        case (ALUopE_i)
            c_op_add: w_alu = w_op1 + w_op2;
            c_op_sub: w_alu = w_op1 - w_op2;
            c_op_and: w_alu = w_op1 & w_op2;
            c_op_or:  w_alu = w_op1 | w_op2;
            c_op_xor: w_alu = w_op1 ^ w_op2;
            c_op_sll: w_alu = w_op1 << w_op2[c_shw-1:0];
            c_op_srl: w_alu = w_op1 >> w_op2[c_shw-1:0];
            default:  w_alu = '0;
        endcase
    end

    mul_iter #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_mul_iter (
        .clk       (clk),
        .rst       (rst),
        .i_start   (w_accept),
        .i_run     (r_state == S_RUN),
        .i_abort   (flush_EX_MEM_i),
        .i_hold    (stall_EX_MEM_i),
        .i_a       (w_op1),
        .i_b       (w_op2),
        .o_done    (w_mul_done),
        .o_product (w_mul_product)
    );

    always_comb begin
        w_state_nxt = r_state;
        busy_o      = 1'b0;
        w_accept    = 1'b0;
        w_bubble    = 1'b0;
        w_load_alu  = 1'b0;
        w_load_mul  = 1'b0;
        if (!rst) begin
            case (r_state)
                S_IDLE: begin
                    if (flush_EX_MEM_i) begin
                        w_bubble = 1'b1;
                    end else if (!stall_EX_MEM_i) begin
                        if (ALUopE_i == c_op_mul) begin
                            busy_o      = 1'b1;
                            w_accept    = 1'b1;
                            w_bubble    = 1'b1;
                            w_state_nxt = S_RUN;
                        end else begin
                            w_load_alu = 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (flush_EX_MEM_i) begin
                        w_bubble    = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else if (stall_EX_MEM_i) begin
                        busy_o = 1'b1;
                    end else if (w_mul_done) begin
                        w_load_mul  = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        busy_o   = 1'b1;
                        w_bubble = 1'b1;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_l_pc    <= '0;
            r_l_wdata <= '0;
            r_l_imm   <= '0;
            r_l_rs    <= '0;
            r_l_wreg  <= '0;
            r_l_ctrl  <= c_ctrl_bubble;
        end else if (w_accept) begin
            r_l_pc    <= PCE_i;
            r_l_wdata <= w_op1;
            r_l_imm   <= imm8E_i;
            r_l_rs    <= rsE_i;
            r_l_wreg  <= w_wreg_e;
            r_l_ctrl  <= w_ctrl_e;
        end
    end

    always_comb begin
        w_src_pc    = PCE_i;
        w_src_wdata = w_op1;
        w_src_imm   = imm8E_i;
        w_src_rs    = rsE_i;
        w_src_wreg  = w_wreg_e;
        w_src_res   = w_alu;
        w_src_ctrl  = w_ctrl_e;
        if (w_load_mul) begin
            w_src_pc    = r_l_pc;
            w_src_wdata = r_l_wdata;
            w_src_imm   = r_l_imm;
            w_src_rs    = r_l_rs;
            w_src_wreg  = r_l_wreg;
            w_src_res   = w_mul_product;
            w_src_ctrl  = r_l_ctrl;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || w_bubble) begin
            r_pc    <= '0;
            r_wdata <= '0;
            r_imm   <= '0;
            r_rs    <= '0;
            r_wreg  <= '0;
            r_res   <= '0;
            r_zero  <= 1'b0;
            r_ctrl  <= c_ctrl_bubble;
        end else if (w_load_alu || w_load_mul) begin
            r_pc    <= w_src_pc;
            r_wdata <= w_src_wdata;
            r_imm   <= w_src_imm;
            r_rs    <= w_src_rs;
            r_wreg  <= w_src_wreg;
            r_res   <= w_src_res;
            r_zero  <= (w_src_res == '0);
            r_ctrl  <= w_src_ctrl;
        end
    end

    assign PCM_o        = r_pc;
    assign WriteDataM_o = r_wdata;
    assign imm8M_o      = r_imm;
    assign rsM_o        = r_rs;
    assign WriteRegM_o  = r_wreg;
    assign alu_outM_o   = r_res;
    assign ZeroM_o      = r_zero;
    assign RegWriteM_o  = r_ctrl.reg_write;
    assign BranchM_o    = r_ctrl.branch;
    assign MemReadM_o   = r_ctrl.mem_read;
    assign MemWriteM_o  = r_ctrl.mem_write;
    assign MemToRegM_o  = r_ctrl.mem_to_reg;
    assign MovM_o       = r_ctrl.mov;

endmodule

`default_nettype wire

// File: tb/tb_ex_stage_mc.sv
// ============================================================================
// Module : tb_ex_stage_mc
// Brief  : Directed + randomized self-checking bench for ex_stage_mc.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ex_stage_mc;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  PCE_i;
    logic [15:0] r1_data_r_i, r2_data_r_i, WBResultM_i, ResultW_i;
    logic [7:0]  imm8E_i;
    logic [3:0]  rsE_i, rtE_i, rdE_i;
    logic [2:0]  ALUopE_i;
    logic        ALUSrcE_i, RegWriteE_i, BranchE_i, MemReadE_i, MemWriteE_i;
    logic        MemToRegE_i, MovE_i, RegDstE_i;
    logic [1:0]  alu_src1_i, alu_src2_i;
    logic        flush_EX_MEM_i, stall_EX_MEM_i;
    logic        busy_o;
    logic [7:0]  PCM_o, imm8M_o;
    logic [15:0] WriteDataM_o, alu_outM_o;
    logic [3:0]  rsM_o, WriteRegM_o;
    logic        ZeroM_o, RegWriteM_o, BranchM_o, MemReadM_o, MemWriteM_o, MemToRegM_o, MovM_o;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    ex_stage_mc dut (
        .clk(clk), .rst(rst), .PCE_i(PCE_i),
        .r1_data_r_i(r1_data_r_i), .r2_data_r_i(r2_data_r_i),
        .imm8E_i(imm8E_i), .rsE_i(rsE_i), .rtE_i(rtE_i), .rdE_i(rdE_i),
        .ALUopE_i(ALUopE_i), .ALUSrcE_i(ALUSrcE_i),
        .RegWriteE_i(RegWriteE_i), .BranchE_i(BranchE_i), .MemReadE_i(MemReadE_i),
        .MemWriteE_i(MemWriteE_i), .MemToRegE_i(MemToRegE_i), .MovE_i(MovE_i),
        .RegDstE_i(RegDstE_i), .WBResultM_i(WBResultM_i), .ResultW_i(ResultW_i),
        .alu_src1_i(alu_src1_i), .alu_src2_i(alu_src2_i),
        .flush_EX_MEM_i(flush_EX_MEM_i), .stall_EX_MEM_i(stall_EX_MEM_i),
        .busy_o(busy_o), .PCM_o(PCM_o), .WriteDataM_o(WriteDataM_o), .imm8M_o(imm8M_o),
        .rsM_o(rsM_o), .WriteRegM_o(WriteRegM_o), .alu_outM_o(alu_outM_o), .ZeroM_o(ZeroM_o),
        .RegWriteM_o(RegWriteM_o), .BranchM_o(BranchM_o), .MemReadM_o(MemReadM_o),
        .MemWriteM_o(MemWriteM_o), .MemToRegM_o(MemToRegM_o), .MovM_o(MovM_o)
    );

    task automatic chk(input string tag, input logic [62:0] obs, input logic [62:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [62:0] obs_vec();
        return {PCM_o, WriteDataM_o, imm8M_o, rsM_o, WriteRegM_o, alu_outM_o, ZeroM_o,
                RegWriteM_o, BranchM_o, MemReadM_o, MemWriteM_o, MemToRegM_o, MovM_o};
    endfunction

    function automatic logic [15:0] pick(input logic [1:0] sel, input logic [15:0] rf);
        if (sel == 2'd1) return WBResultM_i;
        if (sel == 2'd2) return ResultW_i;
        return rf;
    endfunction

    // Reference: what the EX/MEM register must hold for the instruction on the inputs now.
    function automatic logic [62:0] ref_expect();
        logic [15:0] a, b, r;
        logic [31:0] p;
        a = pick(alu_src1_i, r1_data_r_i);
        b = ALUSrcE_i ? {{8{imm8E_i[7]}}, imm8E_i} : pick(alu_src2_i, r2_data_r_i);
        p = a * b;
        case (ALUopE_i)
            3'd0:    r = a + b;
            3'd1:    r = a - b;
            3'd2:    r = a & b;
            3'd3:    r = a | b;
            3'd4:    r = a ^ b;
            3'd5:    r = a << (b % 16);
            3'd6:    r = a >> (b % 16);
            default: r = p[15:0];
        endcase
        return {PCE_i, a, imm8E_i, rsE_i, (RegDstE_i ? rsE_i : rdE_i), r, (r == 16'd0),
                RegWriteE_i, BranchE_i, MemReadE_i, MemWriteE_i, MemToRegE_i, MovE_i};
    endfunction

    task automatic rand_fields();
        PCE_i       = 8'($urandom);
        r1_data_r_i = 16'($urandom);
        r2_data_r_i = 16'($urandom);
        WBResultM_i = 16'($urandom);
        ResultW_i   = 16'($urandom);
        imm8E_i     = 8'($urandom);
        rsE_i       = 4'($urandom);
        rtE_i       = 4'($urandom);
        rdE_i       = 4'($urandom);
        {ALUSrcE_i, RegWriteE_i, BranchE_i, MemReadE_i, MemWriteE_i, MemToRegE_i, MovE_i, RegDstE_i} = 8'($urandom);
        alu_src1_i  = 2'($urandom);
        alu_src2_i  = 2'($urandom);
    endtask

    task automatic rand_instr(input logic [2:0] op);
        rand_fields();
        ALUopE_i       = op;
        flush_EX_MEM_i = 1'b0;
        stall_EX_MEM_i = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic single_op(input string tag);
        logic [62:0] e;
        e = ref_expect();
        #1 chk({tag, "_busy"}, 63'(busy_o), 63'(0));
        tick();
        chk(tag, obs_vec(), e);
    endtask

    // MUL issued on the current inputs; operands are scrambled once accepted.
    task automatic mul_op(input string tag, input int st_at, input int st_len);
        logic [62:0] e;
        int busy_n, bub_n, total;
        e      = ref_expect();
        busy_n = 0;
        bub_n  = 0;
        total  = 17 + st_len;
        for (int c = 0; c < total; c++) begin
            stall_EX_MEM_i = (c >= st_at) && (c < st_at + st_len);
            #1;
            if (busy_o) busy_n++;
            tick();
            if (c < total - 1 && obs_vec() == 63'd0) bub_n++;
            rand_fields();
        end
        stall_EX_MEM_i = 1'b0;
        chk({tag, "_result"}, obs_vec(), e);
        chk({tag, "_busy_cycles"}, 63'(busy_n), 63'(16 + st_len));
        chk({tag, "_bubbles"}, 63'(bub_n), 63'(16 + st_len));
    endtask

    initial begin
        logic [62:0] held;
        rst = 1'b1;
        rand_instr(3'd0);
        tick();
        tick();
        chk("reset_outputs", obs_vec(), 63'd0);
        chk("reset_busy", 63'(busy_o), 63'd0);
        rst = 1'b0;

        // Directed ADD, forwarded SUB, immediate SLL.
        rand_instr(3'd0);
        r1_data_r_i = 16'h0005; r2_data_r_i = 16'h0003; alu_src1_i = 2'd0; alu_src2_i = 2'd0; ALUSrcE_i = 1'b0;
        single_op("add_dir");
        chk("add_dir_val", {alu_outM_o, ZeroM_o}, {16'h0008, 1'b0});
        rand_instr(3'd1);
        alu_src1_i = 2'd1; WBResultM_i = 16'h0010; r2_data_r_i = 16'h0010; alu_src2_i = 2'd0; ALUSrcE_i = 1'b0;
        single_op("sub_fwd");
        chk("sub_fwd_val", {alu_outM_o, ZeroM_o}, {16'h0000, 1'b1});
        rand_instr(3'd5);
        alu_src1_i = 2'd0; r1_data_r_i = 16'h8001; imm8E_i = 8'h01; ALUSrcE_i = 1'b1;
        single_op("sll_imm");
        chk("sll_imm_val", 63'(alu_outM_o), 63'(16'h0002));

        for (int i = 0; i < 24; i++) begin
            rand_instr(3'($urandom_range(0, 6)));
            single_op("alu_rand");
        end

        // Stall and flush while idle.
        held = obs_vec();
        rand_instr(3'd7);
        stall_EX_MEM_i = 1'b1;
        #1 chk("idle_stall_busy", 63'(busy_o), 63'd0);
        tick();
        chk("idle_stall_hold", obs_vec(), held);
        rand_instr(3'd0);
        flush_EX_MEM_i = 1'b1;
        tick();
        chk("idle_flush", obs_vec(), 63'd0);

        // Directed MUL, then a back-to-back random MUL.
        rand_instr(3'd7);
        r1_data_r_i = 16'h0123; r2_data_r_i = 16'h0010; alu_src1_i = 2'd0; alu_src2_i = 2'd0; ALUSrcE_i = 1'b0;
        mul_op("mul_dir", 100, 0);
        chk("mul_dir_val", 63'(alu_outM_o), 63'(16'h1230));
        rand_instr(3'd7);
        mul_op("mul_b2b", 100, 0);

        rand_instr(3'd7);
        r1_data_r_i = 16'h0123; r2_data_r_i = 16'h0010; alu_src1_i = 2'd0; alu_src2_i = 2'd0; ALUSrcE_i = 1'b0;
        mul_op("mul_stall3", 5, 3);
        chk("mul_stall3_val", 63'(alu_outM_o), 63'(16'h1230));
        rand_instr(3'd7);
        mul_op("mul_stall_last", 16, 2);
        for (int i = 0; i < 3; i++) begin
            rand_instr(3'd7);
            mul_op("mul_rand", int'($urandom_range(1, 15)), int'($urandom_range(0, 4)));
        end

        // Flush at cnt == 7 (cycle 8 after acceptance).
        rand_instr(3'd7);
        for (int c = 0; c < 8; c++) tick();
        flush_EX_MEM_i = 1'b1;
        #1 chk("flush_busy", 63'(busy_o), 63'd0);
        tick();
        chk("flush_bubble", obs_vec(), 63'd0);
        rand_instr(3'd0);
        single_op("add_after_flush");

        // Reset in the middle of a MUL.
        rand_instr(3'd7);
        for (int c = 0; c < 6; c++) tick();
        rst = 1'b1;
        #1 chk("rst_mid_busy", 63'(busy_o), 63'd0);
        tick();
        chk("rst_mid_outputs", obs_vec(), 63'd0);
        rst = 1'b0;
        rand_instr(3'd3);
        single_op("or_after_rst");
        rand_instr(3'd7);
        mul_op("mul_after_rst", 100, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ex_stage_mc.md
EX_STAGE_MC -- requirements
Module: ex_stage_mc

Interface
REQ-001 Parameter DATA_WIDTH, 16, operand/result width.
REQ-002 Parameter ADDR_WIDTH, 8, PC width.
REQ-003 Parameter IMM8_WIDTH, 8, immediate width.
REQ-004 Parameter REG_WIDTH, 4, register index width.
REQ-005 Parameter ALUOP_WIDTH, 3, ALU opcode width.
REQ-006 Reset: one clock; reset is synchronous and active-high.
REQ-007 clk  in  1  rising-edge clock.
REQ-008 rst  in  1  synchronous active-high reset.
REQ-009 PCE_i  in  ADDR_WIDTH  PC of EX instruction.
REQ-010 r1_data_r_i, r2_data_r_i  in  DATA_WIDTH  register-file operands.
REQ-011 imm8E_i  in  IMM8_WIDTH  immediate; rsE_i, rtE_i, rdE_i  in  REG_WIDTH  register indices.
REQ-012 ALUopE_i  in  ALUOP_WIDTH  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 MUL.
REQ-013 ALUSrcE_i  in  1  operand2 = sign-extended imm8E_i when 1.
REQ-014 RegWriteE_i, BranchE_i, MemReadE_i, MemWriteE_i, MemToRegE_i, MovE_i, RegDstE_i  in  1 each  control vector.
REQ-015 WBResultM_i, ResultW_i  in  DATA_WIDTH  forwarded MEM/WB data.
REQ-016 alu_src1_i, alu_src2_i  in  2  forward select: 0 RF, 1 WBResultM_i, 2 ResultW_i, 3 RF.
REQ-017 flush_EX_MEM_i, stall_EX_MEM_i  in  1  hazard-unit flush/stall.
REQ-018 busy_o  out  1  EX occupied by multi-cycle MUL; upstream holds ID/EX.
REQ-019 PCM_o, WriteDataM_o, imm8M_o, rsM_o, WriteRegM_o, alu_outM_o  out  registered EX/MEM data.
REQ-020 ZeroM_o  out  1  registered (alu_outM_o == 0).
REQ-021 RegWriteM_o, BranchM_o, MemReadM_o, MemWriteM_o, MemToRegM_o, MovM_o  out  1 each  registered control.

Function
REQ-022 Operand1 = forward mux(alu_src1_i); operand2 = ALUSrcE_i ? sext(imm8E_i) : forward mux(alu_src2_i).
REQ-023 ADD/SUB/logic results modulo 2^DATA_WIDTH; SLL/SRL shift by operand2[$clog2(DATA_WIDTH)-1:0], zero fill.
REQ-024 Single-cycle ops: EX/MEM loaded at the next edge (latency 1); busy_o = 0.
REQ-025 WriteDataE = operand1; WriteRegE = RegDstE_i ? rsE_i : rdE_i.
REQ-026 FSM states IDLE, RUN; IDLE on reset.
REQ-027 IDLE with MUL, no flush/stall: busy_o = 1 (combinational), latch operands, control, PC, imm, indices; cnt = 0; acc = 0; EX/MEM loads bubble; -> RUN.
REQ-028 RUN: one shift-add step per cycle; cnt increments; busy_o = 1 while cnt < DATA_WIDTH-1; EX/MEM loads bubble.
REQ-029 RUN at cnt == DATA_WIDTH-1: busy_o = 0; EX/MEM loads low DATA_WIDTH bits of product plus latched fields; -> IDLE; total EX occupancy DATA_WIDTH+1 cycles.
REQ-030 Latched operands used in RUN; forward inputs ignored after acceptance.
REQ-031 Bubble = all EX/MEM data and control outputs 0.
REQ-032 Priority: rst > flush_EX_MEM_i > stall_EX_MEM_i > normal.
REQ-033 flush in any state: EX/MEM bubble, FSM -> IDLE, MUL aborted, busy_o = 0 that cycle.
REQ-034 stall in RUN: EX/MEM, FSM, cnt, acc frozen; busy_o = 1 (including at cnt == DATA_WIDTH-1).
REQ-035 stall in IDLE: EX/MEM held, no MUL accepted.
REQ-036 Back-to-back MUL: second accepted in the cycle after the first completes.

Reset
REQ-037 rst: all outputs 0, FSM IDLE, cnt = 0, acc = 0; mid-MUL reset discards operation; busy_o = 0 in reset cycle.

Structure
REQ-038 Shared package ex_pkg: ALU opcode constants, FSM state enum, bubble defaults.
REQ-039 Sub-module mul_iter: iterative shift-add multiplier with start/abort/hold/done ports.

Verification
REQ-040 ADD r1=0x0005, r2=0x0003, sel 0/0 -> alu_outM_o = 0x0008 next cycle, ZeroM_o = 0.
REQ-041 SUB, alu_src1_i = 1, WBResultM_i = 0x0010, r2 = 0x0010 -> alu_outM_o = 0x0000, ZeroM_o = 1.
REQ-042 MUL 0x0123 x 0x0010 -> busy_o high 16 cycles, 16 bubbles, then alu_outM_o = 0x1230 with MUL control.
REQ-043 MUL, stall_EX_MEM_i for 3 cycles mid-RUN -> result appears 3 cycles later, value unchanged.
REQ-044 MUL, flush_EX_MEM_i at cnt = 7 -> bubble, busy_o = 0, next ADD completes in 1 cycle.
REQ-045 SLL operand1 = 0x8001, imm8 = 0x01, ALUSrcE_i = 1 -> 0x0002; rst mid-MUL -> all outputs 0, IDLE.
